// File: rtl/line_encoder_seq.sv
// Sequential priority line encoder: captures strobed input lines into a pending set and
// presents them one index per transfer, highest line first. Optional parity: LINE_ENCODER_PARITY_EN.
module line_encoder_seq #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [(1<<N)-1:0]  d_in,
  input  logic               d_strobe,
  output logic [N-1:0]       code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               busy,
  output logic               overrun
`ifdef LINE_ENCODER_PARITY_EN
  ,
  output logic               code_par
`endif
);

  localparam int L = 1 << N;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [L-1:0]   pend_q, pend_d;
  logic [L-1:0]   load_mask;
  logic [L-1:0]   cap_bits;
  logic [N-1:0]   hi_idx;
  logic [N-1:0]   code_q;
  logic           overrun_q;
  logic           pend_any;
  logic           fire;
  logic           load;

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hi_idx = '0;
    for (int i = 0; i < L; i++) begin
      if (pend_q[i]) hi_idx = i[N-1:0];
    end
  end

  assign pend_any   = |pend_q;
  assign code_valid = (state_q == FULL);
  assign fire       = code_valid & code_ready;
  assign load       = ((state_q == EMPTY) | fire) & pend_any;
  assign load_mask  = load ? ({{(L-1){1'b0}}, 1'b1} << hi_idx) : '0;
  assign cap_bits   = d_strobe ? d_in : '0;

  // Capture is OR-ed in after the clear, so a line re-strobed as it leaves stays pending.
  assign pend_d = (pend_q & ~load_mask) | cap_bits;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load)      state_d = FULL;
        else if (fire) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q   <= EMPTY;
      pend_q    <= '0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      if (load) code_q <= hi_idx;
      if (|(cap_bits & pend_q & ~load_mask)) overrun_q <= 1'b1;
    end
  end

  assign code    = code_q;
  assign overrun = overrun_q;
  assign busy    = code_valid | pend_any;

`ifdef LINE_ENCODER_PARITY_EN
  logic code_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    code_par_q <= 1'b0;
    else if (load) code_par_q <= ^hi_idx;
  end

  assign code_par = code_par_q;
`endif

endmodule

// File: tb/tb_line_encoder_seq.sv
// Self-checking bench for line_encoder_seq (N = 3): directed scenarios followed by random
// traffic, all compared every cycle against a set-based reference model.
module tb_line_encoder_seq;

  localparam int N = 3;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [L-1:0]   d_in = '0;
  logic           d_strobe = 1'b0;
  logic           code_ready = 1'b0;
  logic [N-1:0]   code;
  logic           code_valid;
  logic           busy;
  logic           overrun;
`ifdef LINE_ENCODER_PARITY_EN
  logic           code_par;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [L-1:0] m_pend;
  logic         m_valid;
  logic [N-1:0] m_code;
  logic         m_ovr;
  logic         m_par;

  line_encoder_seq #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .d_strobe   (d_strobe),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef LINE_ENCODER_PARITY_EN
    ,
    .code_par   (code_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_code  = '0;
    m_ovr   = 1'b0;
    m_par   = 1'b0;
  endtask

  // One clock edge of the reference: the highest pending line is floor(log2(pend)).
  task automatic model_edge(input logic s, input logic [L-1:0] d, input logic r);
    int           top;
    logic         fire;
    logic         take;
    logic [L-1:0] cap;
    logic [L-1:0] remaining;
    cap       = s ? d : '0;
    fire      = m_valid && r;
    top       = $clog2(int'(m_pend) + 1) - 1;
    take      = (!m_valid || fire) && (m_pend != 0);
    remaining = m_pend;
    if (take) remaining[top] = 1'b0;
    if ((cap & remaining) != 0) m_ovr = 1'b1;
    if (take) begin
      m_code  = top[N-1:0];
      m_valid = 1'b1;
      m_par   = ^top[N-1:0];
    end else if (fire) begin
      m_valid = 1'b0;
    end
    m_pend = remaining | cap;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, code_valid, m_valid);
    check({tag, "_code"}, code, m_code);
    check({tag, "_busy"}, busy, m_valid || (m_pend != 0));
    check({tag, "_overrun"}, overrun, m_ovr);
`ifdef LINE_ENCODER_PARITY_EN
    check({tag, "_par"}, code_par, m_par);
`endif
  endtask

  task automatic step(input string tag, input logic s, input logic [L-1:0] d, input logic r);
    d_strobe   = s;
    d_in       = d;
    code_ready = r;
    @(posedge clk);
    if (rst_n) model_edge(s, d, r);
    else       model_reset();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all("reset_init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step("idle", 1'b0, 8'h00, 1'b1);

    // Single line: code 2 appears two edges after the strobe is driven, for one cycle.
    step("single_cap", 1'b1, 8'b0000_0100, 1'b1);
    check("single_not_yet", code_valid, 1'b0);
    step("single_out", 1'b0, 8'h00, 1'b1);
    check("single_code", code, 3'd2);
    check("single_valid", code_valid, 1'b1);
    step("single_done", 1'b0, 8'h00, 1'b1);
    check("single_busy_low", busy, 1'b0);

    // Multi-line priority with continuous ready.
    step("multi_cap", 1'b1, 8'b1000_0101, 1'b1);
    step("multi_7", 1'b0, 8'h00, 1'b1);
    check("multi_c7", code, 3'd7);
    step("multi_2", 1'b0, 8'h00, 1'b1);
    check("multi_c2", code, 3'd2);
    step("multi_0", 1'b0, 8'h00, 1'b1);
    check("multi_c0", code, 3'd0);
    step("multi_end", 1'b0, 8'h00, 1'b1);
    check("multi_empty", code_valid, 1'b0);

    // Backpressure: code 7 holds for 5 stalled cycles.
    step("bp_cap", 1'b1, 8'b1000_0101, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", 1'b0, 8'h00, 1'b0);
      check("bp_c7", code, 3'd7);
    end
    step("bp_2", 1'b0, 8'h00, 1'b1);
    check("bp_c2", code, 3'd2);
    step("bp_0", 1'b0, 8'h00, 1'b1);
    check("bp_c0", code, 3'd0);
    step("bp_end", 1'b0, 8'h00, 1'b1);

    // Strobe with no lines changes nothing.
    step("zero_strobe", 1'b1, 8'h00, 1'b1);
    check("zero_busy", busy, 1'b0);

    // Overrun: line 0 re-captured while still pending.
    step("ovr_cap1", 1'b1, 8'b0000_0011, 1'b0);
    step("ovr_cap2", 1'b1, 8'b0000_0001, 1'b0);
    check("ovr_set", overrun, 1'b1);
    check("ovr_c1", code, 3'd1);
    step("ovr_0", 1'b0, 8'h00, 1'b1);
    check("ovr_c0", code, 3'd0);
    step("ovr_end", 1'b0, 8'h00, 1'b1);
    check("ovr_empty", code_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // Re-strobing the line currently held must not flag overrun.
    step("held_cap", 1'b1, 8'b0100_0000, 1'b0);
    step("held_out", 1'b0, 8'h00, 1'b0);
    step("held_again", 1'b1, 8'b0100_0000, 1'b0);
    step("held_re6", 1'b0, 8'h00, 1'b1);
    check("held_c6", code, 3'd6);
    step("held_end", 1'b0, 8'h00, 1'b1);

    // Mid-stream asynchronous reset, then capture on the first edge after release.
    step("mid_cap", 1'b1, 8'hF0, 1'b0);
    step("mid_out", 1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_code", code, 3'd0);
    check("rst_valid", code_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    step("rst_hold", 1'b0, 8'h00, 1'b1);
    step("rst_hold", 1'b1, 8'hFF, 1'b1);
    rst_n = 1'b1;
    step("rel_cap", 1'b1, 8'b0001_0000, 1'b1);
    check("rel_busy", busy, 1'b1);
    step("rel_out", 1'b0, 8'h00, 1'b1);
    check("rel_c4", code, 3'd4);
    step("rel_end", 1'b0, 8'h00, 1'b1);
    check("rel_empty", code_valid, 1'b0);

    // Parity scenario.
    step("par_cap", 1'b1, 8'b1000_1000, 1'b1);
    step("par_7", 1'b0, 8'h00, 1'b1);
    check("par_c7", code, 3'd7);
`ifdef LINE_ENCODER_PARITY_EN
    check("par_p1", code_par, 1'b1);
`endif
    step("par_3", 1'b0, 8'h00, 1'b1);
    check("par_c3", code, 3'd3);
`ifdef LINE_ENCODER_PARITY_EN
    check("par_p0", code_par, 1'b0);
`endif
    step("par_end", 1'b0, 8'h00, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic         s;
      logic [L-1:0] d;
      logic         r;
      s = ($urandom_range(0, 9) < 4);
      d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      r = ($urandom_range(0, 9) < 6);
      step("rand", s, d, r);
    end
    for (int i = 0; i < 10; i++) step("drain", 1'b0, 8'h00, 1'b1);
    check("drain_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_encoder_seq.md
LINE_ENCODER_SEQ -- requirements
Module: line_encoder_seq

Interface
REQ-001 Parameter N, default 3: code width; the number of input lines is L = 2^N.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 d_in  input  L  data lines to encode; bit i = line Di.
REQ-005 d_strobe  input  1  capture pulse; d_in is sampled on any clk edge where it is high.
REQ-006 code  output  N  index of the line currently being presented.
REQ-007 code_valid  output  1  code holds a valid index.
REQ-008 code_ready  input  1  consumer accepts code; a transfer (fire) = code_valid & code_ready.
REQ-009 busy  output  1  equals code_valid | (pend != 0).
REQ-010 overrun  output  1  sticky flag: a captured line was already pending.
REQ-011 code_par  output  1  even parity of code; the port is present only when LINE_ENCODER_PARITY_EN is defined.

Function
REQ-012 The block SHALL hold an internal L-bit pending register, pend.
- pend_next = (pend & ~load_mask) | (d_strobe ? d_in : 0).
- load_mask is the one-hot of the bit moved into the output register this cycle, or zero if no bit moves.
REQ-013 The output register SHALL have exactly two states:
- EMPTY: code_valid = 0.
- FULL: code_valid = 1.
REQ-014 Load condition: when (EMPTY or fire) and pend != 0, on the next edge the block SHALL:
- load code with the index of the highest set bit of pend;
- clear that bit in pend;
- enter or remain in FULL.
REQ-015 When fire occurs and pend == 0, the block SHALL return to EMPTY on the next edge; code keeps its last value.
REQ-016 While FULL and code_ready = 0, code and code_valid SHALL remain stable.
REQ-017 Latency: with the block idle, d_strobe at edge t SHALL produce code_valid high after edge t+2 (pend updates at t+1, output loads at t+2).
REQ-018 Throughput with code_ready held high SHALL be one code per cycle, with no bubble between pending bits.
REQ-019 Merging rules:
- d_strobe with d_in = 0 SHALL change nothing.
- Bits captured while FULL SHALL merge into pend and be emitted in priority order with the remaining bits.
REQ-020 Simultaneous events: a d_strobe bit equal to the bit being loaded the same cycle SHALL remain set in pend, because capture takes precedence over clear; that line is emitted again later.
REQ-021 A d_strobe bit equal to the index currently held in FULL SHALL be set in pend and emitted again; it SHALL NOT set overrun.
REQ-022 overrun SHALL set on any edge where d_strobe & d_in & pend & ~load_mask != 0, and SHALL clear only on reset.
REQ-023 The index arithmetic SHALL be an unsigned N-bit priority encode, with the highest index winning; no other width conversion is permitted.

Reset
REQ-024 While rst_n = 0, the block SHALL asynchronously force: pend = 0, state = EMPTY, code = 0, code_valid = 0, overrun = 0, busy = 0, code_par = 0.
REQ-025 Reset mid-operation SHALL discard all pending and presented codes; after rst_n deasserts, no code is emitted until a new d_strobe.
REQ-026 Deassertion of rst_n SHALL take effect at the first clk edge after release; a d_strobe on that edge SHALL be captured.

Configuration
REQ-027 With LINE_ENCODER_PARITY_EN defined, code_par SHALL equal the XOR of the code bits, registered together with code and valid whenever code_valid = 1.
REQ-028 Without LINE_ENCODER_PARITY_EN, the code_par port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (N = 3)
REQ-029 Reset check: hold rst_n = 0 mid-stream -> code = 0, code_valid = 0, busy = 0, overrun = 0 immediately, without waiting for a clk edge.
REQ-030 Single line: d_in = 8'b0000_0100 strobed one cycle, code_ready = 1 -> code = 2, valid for exactly one cycle starting two edges later; busy low the cycle after.
REQ-031 Multi-line priority: d_in = 8'b1000_0101, code_ready = 1 -> codes 7, 2, 0 on three consecutive cycles, then code_valid = 0.
REQ-032 Backpressure: as REQ-031 but code_ready = 0 for 5 cycles -> code = 7 stable with valid high; after release -> 2, then 0.
REQ-033 Overrun: strobe 8'b0000_0011 with code_ready = 0, then strobe 8'b0000_0001 -> overrun = 1 and stays 1; codes 1, 0 emitted once each.
REQ-034 Parity build: strobe 8'b1000_1000, code_ready = 1 -> code 7 with code_par = 1, then code 3 with code_par = 0.
